// File: rtl/clk_ratio_detect.sv
// clk_ratio_detect
//   Samples a divided clock (clk_in) in the clk domain and recovers its period
//   (ratio), high/low phase lengths, odd-ratio flag and lock status. Used to
//   confirm a programmable divider output and to flag stalled/bypassed outputs.
//
// Ports:
//   clk        in   sampling clock (same source that feeds the divider)
//   rst_n      in   asynchronous active-low reset
//   enable     in   measurement enable; low forces IDLE
//   clk_in     in   divided clock under test, asynchronous to clk
//   ratio      out  last measured period in clk cycles (rise to rise)
//   high_len   out  clk cycles clk_in was high in the last period
//   low_len    out  clk cycles clk_in was low in the last period
//   odd        out  ratio[0] of the last measurement
//   meas_valid out  one-cycle pulse when ratio/high_len/low_len update
//   locked     out  LOCK_CNT consecutive equal periods observed
//   timeout    out  sticky no-edge/overflow flag

module clk_ratio_detect #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clk_in,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             odd,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StSeek,
        StMeasure
    } state_e;

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [3:0]       LockMax    = 4'(LOCK_CNT);

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;
    logic                   rise;
    logic [CNT_W-1:0]       pcnt_q;
    logic [CNT_W-1:0]       hcnt_q;
    logic [3:0]             lock_cnt_q;
    logic [3:0]             lock_next;

    // Synchroniser and edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            s_d_q  <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    // A zero lock count means no earlier measurement in this run, so the
    // stale ratio register must not be trusted for the equality test.
    always_comb begin
        lock_next = 4'd1;
        if ((lock_cnt_q != 4'd0) && (pcnt_q == ratio)) begin
            lock_next = (lock_cnt_q >= LockMax) ? LockMax : lock_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pcnt_q     <= '0;
            hcnt_q     <= '0;
            lock_cnt_q <= 4'd0;
            ratio      <= '0;
            high_len   <= '0;
            low_len    <= '0;
            odd        <= 1'b0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                // Enable low wins over any edge or timeout this cycle.
                state_q    <= StIdle;
                pcnt_q     <= '0;
                hcnt_q     <= '0;
                lock_cnt_q <= 4'd0;
                locked     <= 1'b0;
                timeout    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StSeek;
                    end
                    StSeek: begin
                        if (rise) begin
                            pcnt_q  <= CntOne;
                            hcnt_q  <= CntOne;
                            state_q <= StMeasure;
                        end else if (pcnt_q >= TimeoutVal) begin
                            timeout <= 1'b1;
                            pcnt_q  <= '0;
                        end else begin
                            pcnt_q <= pcnt_q + CntOne;
                        end
                    end
                    StMeasure: begin
                        // A rise coincident with the limit is still a valid edge.
                        if (rise) begin
                            ratio      <= pcnt_q;
                            high_len   <= hcnt_q;
                            low_len    <= pcnt_q - hcnt_q;
                            odd        <= pcnt_q[0];
                            meas_valid <= 1'b1;
                            timeout    <= 1'b0;
                            lock_cnt_q <= lock_next;
                            locked     <= (lock_next == LockMax);
                            pcnt_q     <= CntOne;
                            hcnt_q     <= CntOne;
                        end else if ((pcnt_q >= TimeoutVal) || (pcnt_q == CntMax)) begin
                            timeout    <= 1'b1;
                            locked     <= 1'b0;
                            lock_cnt_q <= 4'd0;
                            pcnt_q     <= '0;
                            hcnt_q     <= '0;
                            state_q    <= StSeek;
                        end else begin
                            pcnt_q <= pcnt_q + CntOne;
                            if (s) begin
                                hcnt_q <= hcnt_q + CntOne;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Self-checking bench for clk_ratio_detect. A divider model drives clk_in from
// clk; a period-level reference model turns each generated clk_in rising edge
// into an expected measurement (period, high time, lock state) due SYNC+1
// cycles later.

module tb_clk_ratio_detect;

    localparam int S    = 2;
    localparam int LOCK = 4;
    localparam int TMO  = 255;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       clk_in = 1'b0;
    logic [7:0] ratio;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic       odd;
    logic       meas_valid;
    logic       locked;
    logic       timeout;

    clk_ratio_detect #(
        .CNT_W      (8),
        .SYNC_STAGES(S),
        .LOCK_CNT   (LOCK),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clk_in    (clk_in),
        .ratio     (ratio),
        .high_len  (high_len),
        .low_len   (low_len),
        .odd       (odd),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        int due;
        int r;
        int h;
        bit lk;
    } ev_t;

    ev_t evq[$];

    // Reference model state
    bit model_en  = 1'b0;
    bit armed     = 1'b0;
    bit have_meas = 1'b0;
    bit prev_v    = 1'b0;
    int last_rise = 0;
    int hi_cnt    = 0;
    int run       = 0;
    int last_r    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_flush();
        evq.delete();
        armed     = 1'b0;
        have_meas = 1'b0;
        run       = 0;
    endtask

    // Called with the clk_in value driven for cycle cyc.
    task automatic model_drive(input bit v);
        int  p;
        ev_t e;
        if (model_en && v && !prev_v) begin
            p = cyc - last_rise;
            if (armed && p <= TMO) begin
                run = (have_meas && p == last_r) ? ((run < LOCK) ? run + 1 : LOCK) : 1;
                e.due = cyc + S + 1;
                e.r   = p;
                e.h   = hi_cnt;
                e.lk  = (run == LOCK);
                evq.push_back(e);
                last_r    = p;
                have_meas = 1'b1;
            end else begin
                // First edge of a run, or a gap too long to be a period.
                have_meas = 1'b0;
                run       = 0;
            end
            armed     = 1'b1;
            last_rise = cyc;
            hi_cnt    = 0;
        end
        if (v) hi_cnt++;
        prev_v = v;
    endtask

    task automatic step(input bit v);
        ev_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (evq.size() > 0 && evq[0].due == cyc) begin
            e = evq.pop_front();
            check("meas_valid", meas_valid, 1);
            check("ratio", ratio, e.r);
            check("high_len", high_len, e.h);
            check("low_len", low_len, e.r - e.h);
            check("odd", odd, e.r % 2);
            check("locked", locked, e.lk);
            check("timeout_at_meas", timeout, 0);
        end else begin
            check("meas_valid_quiet", meas_valid, 0);
        end
        clk_in = v;
        model_drive(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // Divider output: high for ceil(d/2), low for floor(d/2).
    task automatic run_div(input int d, input int nper);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < (d + 1) / 2; i++) step(1'b1);
            for (int i = 0; i < d / 2; i++) step(1'b0);
        end
    endtask

    task automatic drop_enable();
        enable   = 1'b0;
        model_en = 1'b0;
        model_flush();
    endtask

    task automatic raise_enable();
        enable   = 1'b1;
        model_en = 1'b1;
        model_flush();
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_ratio", ratio, 0);
        check("rst_high", high_len, 0);
        check("rst_low", low_len, 0);
        check("rst_odd", odd, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        raise_enable();
        idle(6);

        // Directed divider ratios, including a switch while locked
        run_div(4, 6);
        check("locked_div4", locked, 1);
        run_div(5, 6);
        run_div(6, 6);
        run_div(10, 6);
        check("locked_div10", locked, 1);

        // Stalled divider output
        idle(300);
        check("stall_timeout", timeout, 1);
        check("stall_locked", locked, 0);
        run_div(3, 6);
        check("restart_timeout", timeout, 0);

        // Long periods, including one exactly at the limit
        run_div(200, 5);
        run_div(255, 5);
        check("locked_div255", locked, 1);

        // Randomised divider settings
        for (int k = 0; k < 6; k++) begin
            run_div(int'($urandom_range(2, 40)), int'($urandom_range(2, 7)));
        end

        // Enable drop mid-period while locked
        run_div(7, 5);
        step(1'b1);
        step(1'b1);
        drop_enable();
        idle(2);
        check("dis_locked", locked, 0);
        check("dis_timeout", timeout, 0);
        idle(4);
        raise_enable();
        idle(6);
        run_div(6, 5);

        // Enable drop clears a pending timeout
        idle(300);
        check("stall2_timeout", timeout, 1);
        drop_enable();
        idle(2);
        check("dis_clears_timeout", timeout, 0);
        raise_enable();
        idle(6);

        // Reset mid-period
        run_div(8, 5);
        step(1'b1);
        step(1'b1);
        rst_n  = 1'b0;
        clk_in = 1'b0;
        prev_v = 1'b0;
        model_flush();
        #1;
        check("mid_rst_ratio", ratio, 0);
        check("mid_rst_valid", meas_valid, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_timeout", timeout, 0);
        idle(3);
        rst_n = 1'b1;
        idle(6);
        run_div(9, 5);
        idle(10);
        check("queue_drained", evq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
